// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver: shadowed display value committed at frame
// boundaries, leading-zero blanking, per-digit blink and dead-time blanking on digit change.
module seg_scan_driver #(
  parameter int BLINK_DIV = 25000000,
  parameter int DEAD_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  scan_sel,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_in,
  input  logic        lz_en,
  output logic        ack,
  output logic        pend,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam int DW = (DEAD_CYC < 1) ? 1 : $clog2(DEAD_CYC + 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [BW-1:0] BLINK_ONE = BW'(1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC);
  localparam logic [DW-1:0] DEAD_ONE  = DW'(1);
  localparam logic [DW-1:0] DEAD_ZERO = DW'(0);

  // Active-high {g,f,e,d,c,b,a}; b and d drawn lowercase.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  4'hF: hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

  logic [1:0]    prev_sel_q;
  logic          pend_q, pend_d, ack_q, ack_d;
  logic [15:0]   pnd_data_q, pnd_data_d, shd_data_q, shd_data_d;
  logic [3:0]    pnd_dp_q, pnd_dp_d, shd_dp_q, shd_dp_d;
  logic [3:0]    pnd_blink_q, pnd_blink_d, shd_blink_q, shd_blink_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_edge;
  logic          lz_blank;
  logic [15:0]   higher;

  // Pending capture and tear-free commit into the shadow at a frame boundary.
  always_comb begin
    pend_d      = pend_q;
    ack_d       = 1'b0;
    pnd_data_d  = pnd_data_q;
    pnd_dp_d    = pnd_dp_q;
    pnd_blink_d = pnd_blink_q;
    shd_data_d  = shd_data_q;
    shd_dp_d    = shd_dp_q;
    shd_blink_d = shd_blink_q;
    frame_edge  = (prev_sel_q == 2'd3) && (scan_sel == 2'd0);
    if (pend_q && frame_edge) begin
      shd_data_d  = pnd_data_q;
      shd_dp_d    = pnd_dp_q;
      shd_blink_d = pnd_blink_q;
      pend_d      = 1'b0;
      ack_d       = 1'b1;
    end else if (load && !pend_q) begin
      pnd_data_d  = data_in;
      pnd_dp_d    = dp_in;
      pnd_blink_d = blink_in;
      pend_d      = 1'b1;
    end else begin
      ack_d = 1'b0;
    end
  end

  // Free-running blink phase and dead-time countdown.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_ONE;
    blink_off_d = blink_off_q;
    if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = {BW{1'b0}};
      blink_off_d = ~blink_off_q;
    end else begin
      blink_off_d = blink_off_q;
    end
    if (scan_sel != prev_sel_q) begin
      dead_d = DEAD_LOAD;
    end else if (dead_q != DEAD_ZERO) begin
      dead_d = dead_q - DEAD_ONE;
    end else begin
      dead_d = dead_q;
    end
  end

  // Next anode/segment pattern for the selected digit.
  always_comb begin
    an_d     = 4'hF;
    seg_d    = 8'hFF;
    higher   = shd_data_q >> {scan_sel, 2'b00};
    lz_blank = lz_en && (scan_sel != 2'd0) && (higher == 16'h0000);
    if (dead_d != DEAD_ZERO) begin
      an_d  = 4'hF;
      seg_d = 8'hFF;
    end else begin
      an_d = ~(4'b0001 << scan_sel);
      if (blink_off_q && shd_blink_q[scan_sel]) begin
        seg_d = 8'hFF;
      end else if (lz_blank) begin
        seg_d = {~shd_dp_q[scan_sel], 7'h7F};
      end else begin
        seg_d = ~{shd_dp_q[scan_sel], hex7(higher[3:0])};
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sel_q  <= 2'd0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
      pnd_data_q  <= 16'h0000;
      pnd_dp_q    <= 4'h0;
      pnd_blink_q <= 4'h0;
      shd_data_q  <= 16'h0000;
      shd_dp_q    <= 4'h0;
      shd_blink_q <= 4'h0;
      blink_cnt_q <= {BW{1'b0}};
      blink_off_q <= 1'b0;
      dead_q      <= DEAD_ZERO;
      an_q        <= 4'hF;
      seg_q       <= 8'hFF;
    end else begin
      prev_sel_q  <= scan_sel;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
      pnd_data_q  <= pnd_data_d;
      pnd_dp_q    <= pnd_dp_d;
      pnd_blink_q <= pnd_blink_d;
      shd_data_q  <= shd_data_d;
      shd_dp_q    <= shd_dp_d;
      shd_blink_q <= shd_blink_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      dead_q      <= dead_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign ack  = ack_q;
  assign pend = pend_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed plan items plus randomized scanning,
// every cycle compared against a behavioural model of the display rules.
module tb_seg_scan_driver;
  localparam int BD = 8;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  scan_sel;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in, blink_in;
  logic        lz_en;
  logic        ack, pend;
  logic [3:0]  an;
  logic [7:0]  seg;

  seg_scan_driver #(.BLINK_DIV(BD), .DEAD_CYC(DC)) dut (
    .clk(clk), .rst_n(rst_n), .scan_sel(scan_sel), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blink_in(blink_in), .lz_en(lz_en), .ack(ack), .pend(pend),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int         m_data, m_pdata, m_prev, m_dead, m_bcnt;
  logic [3:0] m_dp, m_blink, m_pdp, m_pblink;
  bit         m_pend, m_boff;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_ack, exp_pend;

  task automatic model_reset();
    m_data = 0; m_pdata = 0; m_prev = 0; m_dead = 0; m_bcnt = 0;
    m_dp = 4'h0; m_blink = 4'h0; m_pdp = 4'h0; m_pblink = 4'h0;
    m_pend = 1'b0; m_boff = 1'b0;
    exp_an = 4'hF; exp_seg = 8'hFF; exp_ack = 1'b0; exp_pend = 1'b0;
  endtask

  task automatic model_step();
    int d, nd, hi;
    logic [7:0] s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    d  = int'(scan_sel);
    nd = (d != m_prev) ? DC : ((m_dead > 0) ? m_dead - 1 : 0);
    if (nd > 0) begin
      exp_an = 4'hF; exp_seg = 8'hFF;
    end else begin
      exp_an = 4'hF ^ 4'(1 << d);
      hi = m_data >> (4 * d);
      if (m_boff && m_blink[d]) exp_seg = 8'hFF;
      else begin
        s = {m_dp[d], ((lz_en && d > 0 && hi == 0) ? 7'h00 : seg_tab[hi % 16])};
        exp_seg = ~s;
      end
    end
    exp_ack = m_pend && (m_prev == 3) && (d == 0);
    if (exp_ack) begin
      m_data = m_pdata; m_dp = m_pdp; m_blink = m_pblink; m_pend = 1'b0;
    end else if (load && !m_pend) begin
      m_pdata = int'(data_in); m_pdp = dp_in; m_pblink = blink_in; m_pend = 1'b1;
    end
    exp_pend = m_pend;
    m_bcnt++;
    if (m_bcnt == BD) begin
      m_bcnt = 0;
      m_boff = !m_boff;
    end
    m_prev = d;
    m_dead = nd;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("an", 16'(an), 16'(exp_an));
    check("seg", 16'(seg), 16'(exp_seg));
    check("pend", 16'(pend), 16'(exp_pend));
    check("ack", 16'(ack), 16'(exp_ack));
  endtask

  task automatic step_sel(input logic [1:0] s, input int n);
    scan_sel = s;
    repeat (n) cycle();
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    data_in = v; dp_in = dp; blink_in = bl; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    model_reset();
    #1;
    check("async_rst_an", 16'(an), 16'h000F);
    check("async_rst_seg", 16'(seg), 16'h00FF);
    check("async_rst_pend", 16'(pend), 16'h0000);
    check("async_rst_ack", 16'(ack), 16'h0000);
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int nb, nlit;
    logic [1:0] nsel;
    rst_n = 1'b0; scan_sel = 2'd0; load = 1'b0; data_in = 16'h0000;
    dp_in = 4'h0; blink_in = 4'h0; lz_en = 1'b0;
    model_reset();

    // Reset held while the scan keeps moving
    for (int i = 0; i < 6; i++) begin
      scan_sel = 2'(i);
      cycle();
    end
    check("rst_an", 16'(an), 16'h000F);
    check("rst_seg", 16'(seg), 16'h00FF);
    rst_n = 1'b1;
    scan_sel = 2'd0;
    repeat (DC + 1) cycle();
    check("rst_digit0", 16'(seg), 16'h00C0);

    // Mid-frame load, ignored second load, commit at 3->0
    step_sel(2'd1, 2);
    load_val(16'h12AF, 4'b0100, 4'b0000);
    check("pend_set", 16'(pend), 16'h0001);
    load_val(16'hFFFF, 4'b1111, 4'b0000);
    check("pend_hold", 16'(pend), 16'h0001);
    step_sel(2'd2, 6);
    step_sel(2'd3, 6);
    check("pend_before_edge", 16'(pend), 16'h0001);
    step_sel(2'd0, 1);
    check("ack_pulse", 16'(ack), 16'h0001);
    check("pend_clear", 16'(pend), 16'h0000);
    cycle();
    check("ack_single", 16'(ack), 16'h0000);
    repeat (DC) cycle();
    check("d0_F", 16'(seg), 16'h008E);
    step_sel(2'd2, DC + 1);
    check("d2_2dp", 16'(seg), 16'h0024);
    check("d2_an", 16'(an), 16'h000B);
    step_sel(2'd3, DC + 1);
    check("d3_1", 16'(seg), 16'h00F9);

    // Leading-zero blanking
    lz_en = 1'b1;
    load_val(16'h0070, 4'b0000, 4'b0000);
    step_sel(2'd0, DC + 1);
    check("lz_d0", 16'(seg), 16'h00C0);
    step_sel(2'd1, DC + 1);
    check("lz_d1", 16'(seg), 16'h00F8);
    step_sel(2'd2, DC + 1);
    check("lz_d2", 16'(seg), 16'h00FF);
    step_sel(2'd3, DC + 1);
    check("lz_d3", 16'(seg), 16'h00FF);
    load_val(16'h0000, 4'b0000, 4'b0000);
    step_sel(2'd0, DC + 1);
    check("lz0_d0", 16'(seg), 16'h00C0);
    step_sel(2'd1, DC + 1);
    check("lz0_d1", 16'(seg), 16'h00FF);
    step_sel(2'd2, DC + 1);
    check("lz0_d2", 16'(seg), 16'h00FF);
    step_sel(2'd3, DC + 1);
    check("lz0_d3", 16'(seg), 16'h00FF);
    lz_en = 1'b0;

    // Dead time, including a restart partway through
    step_sel(2'd1, DC + 1);
    scan_sel = 2'd2;
    for (int i = 0; i < DC; i++) begin
      cycle();
      check("dead_an", 16'(an), 16'h000F);
    end
    cycle();
    check("dead_end_an", 16'(an), 16'h000B);
    scan_sel = 2'd1;
    repeat (2) cycle();
    scan_sel = 2'd2;
    for (int i = 0; i < DC; i++) begin
      cycle();
      check("dead_restart_an", 16'(an), 16'h000F);
    end
    cycle();
    check("dead_restart_end", 16'(an), 16'h000B);

    // Blink on digit 0 only; 32 cycles span exactly four half-periods
    step_sel(2'd3, DC + 1);
    load_val(16'h1234, 4'b0000, 4'b0001);
    step_sel(2'd0, DC + 1);
    nb = 0; nlit = 0;
    for (int i = 0; i < 4 * BD; i++) begin
      cycle();
      if (seg == 8'hFF) nb++;
      if (seg == 8'h99) nlit++;
    end
    check("blink_d0_blank", 16'(nb), 16'(2 * BD));
    check("blink_d0_lit", 16'(nlit), 16'(2 * BD));
    step_sel(2'd1, DC + 1);
    nb = 0;
    for (int i = 0; i < 4 * BD; i++) begin
      cycle();
      if (seg == 8'hFF) nb++;
    end
    check("blink_d1_steady", 16'(nb), 16'h0000);

    // Randomized scanning with random loads, lz toggling and occasional resets
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 7) == 0) nsel = 2'($urandom_range(0, 3));
      else nsel = scan_sel + 2'd1;
      scan_sel = nsel;
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      for (int h = 0; h < int'($urandom_range(1, 10)); h++) begin
        load     = ($urandom_range(0, 9) == 0);
        data_in  = 16'($urandom);
        if ($urandom_range(0, 3) == 0) data_in = data_in >> (4 * $urandom_range(1, 3));
        dp_in    = 4'($urandom);
        blink_in = 4'($urandom);
        cycle();
      end
      load = 1'b0;
      if ($urandom_range(0, 199) == 0) async_reset();
    end
    async_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Four-digit, time-multiplexed 7-segment driver sitting directly downstream of the scan controller. Consumes the controller's 2-bit digit-select and produces registered, active-low anode and segment outputs.
Holds a tear-free shadow copy of the displayed value, updated only at frame boundaries via a load/ack handshake. Adds optional leading-zero blanking, per-digit blinking and dead-time blanking on digit changes to suppress ghosting.

Parameters:
BLINK_DIV, 25000000, clk cycles per blink half-period (blink toggle interval); must be >= 2
DEAD_CYC, 4, clk cycles of all-anodes-off after each scan_sel change; 0 disables dead time

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
scan_sel  in  2  digit index from scan controller; 0 = rightmost digit (an[0]), 3 = leftmost
load  in  1  request to update displayed value; data_in/dp_in/blink_in sampled when load=1 and pend=0
data_in  in  16  four hex nibbles; [3:0] = digit 0 ... [15:12] = digit 3
dp_in  in  4  decimal point per digit, 1 = lit
blink_in  in  4  per-digit blink enable
lz_en  in  1  leading-zero blanking enable (live, not shadowed)
ack  out  1  one-cycle pulse when the pending value is committed to the shadow
pend  out  1  1 while a captured value waits for a frame boundary
an  out  4  anode enables, active-low, one-hot-low or all-high
seg  out  8  {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst_n=0, async): an=4'b1111, seg=8'hFF, ack=0, pend=0; shadow data=0, dp=0, blink=0; blink phase=on; blink counter=0; dead counter=0; prev_sel=0.
- Capture: on clk with load=1 and pend=0, latch data_in/dp_in/blink_in into the pending register and set pend=1. load while pend=1 is ignored; no queueing and no overwrite.
- Frame boundary: the cycle where prev_sel==3 and scan_sel==0.
- Commit: at a frame boundary with pend=1, copy pending to shadow, clear pend, and pulse ack=1 for exactly that next cycle.
- Load plus boundary in the same cycle with pend=0: capture only. Commit waits for the next boundary. Frames are never torn.
- prev_sel: registers scan_sel every cycle.
- Dead time: when scan_sel != prev_sel, load the dead counter with DEAD_CYC. While the counter is nonzero, an=4'b1111 and seg=8'hFF, and the counter decrements each cycle. An additional scan_sel change during dead time reloads the counter.
- Normal drive (dead counter 0), registered with 1 cycle latency from scan_sel:
  - an = ~(4'b0001 << scan_sel).
  - seg = ~{dp[d], hex_to_7seg(nibble[d])}, where d = scan_sel.
  - Decoder: standard hex 0-F; b and d are lowercase, all other letters uppercase.
- Leading-zero blanking (lz_en=1): digit d is blanked (seg[6:0]=7'h7F) if its nibble and every higher nibble are 0, for d = 3..1. Digit 0 is never blanked, so value 0 shows "   0". The dp bit is unaffected by lz blanking.
- Blink: free-running counter 0..BLINK_DIV-1; at wrap, toggle phase. While phase=off, every digit with shadow blink bit = 1 shows seg=8'hFF; its anode is still driven.
- Blink counter and phase free-run regardless of load, commit, or dead time.
- Reset asserted mid-frame or mid-pend: everything returns to reset values immediately. Any pending value is discarded and no ack is produced.
- Width rules: blink counter is $clog2(BLINK_DIV) bits; dead counter is $clog2(DEAD_CYC+1) bits, with a minimum of 1 bit.

Test Plan:
- Reset: hold rst_n=0 with scan_sel cycling -> an=4'hF, seg=8'hFF, pend=0, ack=0; release -> digit 0 shows "0" (seg=8'hC0) after DEAD_CYC+1 cycles.
- Load data_in=16'h12AF, dp_in=4'b0100, mid-frame -> pend=1 until the 3->0 transition; ack pulses once; then sel=0 gives seg=8'h8E ("F"), sel=2 gives seg=8'h24 ("2" with dp), sel=3 gives seg=8'hF9 ("1").
- Second load while pend=1 with data_in=16'hFFFF -> ignored; the shadow after commit equals the first value 16'h12AF.
- lz_en=1, value 16'h0070: digits 3 and 2 give seg=8'hFF; digit 1 gives 8'hF8 ("7"); digit 0 gives 8'hC0. Value 16'h0000 -> only digit 0 is lit.
- Dead time: DEAD_CYC=4, step scan_sel 1->2 -> an=4'hF for exactly 4 cycles, then an=4'b1011. Stepping again at cycle 2 restarts a full 4-cycle count.
- Blink: BLINK_DIV=8, blink_in=4'b0001 committed -> digit 0 alternates lit/blank every 8 cycles; digits 1-3 are unaffected.
